load_store_unit: RTL and testbench

Multi-cycle load/store unit for the single-cycle RV32I datapath. It sits downstream of the execute stage. It accepts an effective address, store data and funct3 for LW/LH/LB/LHU/LBU/SW/SH/SB, and drives a word-wide data memory through a req/ack handshake. It returns sign- or zero-extended load data, tagged with the destination register, for write-back into the register file.

---
 rtl/load_store_unit.sv | 236 +++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle RV32I load/store engine between execute and a
// word-wide data memory. Decodes LB/LH/LW/LBU/LHU/SB/SH/SW, rejects illegal
// or misaligned accesses without touching memory, drives a req/ack memory
// port with a wait-cycle timeout, and returns extended load data tagged
// with the destination register as a one-cycle response pulse.
//
// Handshake: an access transfers on a rising edge where req_valid and
// req_ready are both high; req_ready is high only in IDLE, and an upstream
// stage that sees req_ready low keeps req_valid and its payload stable.
// The memory side completes on an edge where mem_req and mem_ack are both
// high; mem_addr/mem_we/mem_wstrb/mem_wdata hold steady while mem_req is high.
module load_store_unit #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    output logic        resp_we,
    output logic [4:0]  resp_rd,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Counter only has to reach MEM_TIMEOUT-1.
    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Request fields still needed after the memory word comes back.
    logic          lat_store_q, lat_store_d;
    logic [2:0]    lat_funct3_q, lat_funct3_d;
    logic [1:0]    lat_off_q, lat_off_d;
    logic [4:0]    lat_rd_q, lat_rd_d;

    logic          mem_req_d, mem_we_d;
    logic [31:0]   mem_addr_d, mem_wdata_d;
    logic [3:0]    mem_wstrb_d;
    logic          resp_valid_d, resp_we_d, resp_err_d;
    logic [4:0]    resp_rd_d;
    logic [31:0]   resp_data_d;

    logic          dec_legal, dec_misaligned;
    logic [3:0]    dec_strb;
    logic [31:0]   dec_wdata;

    // Pick the addressed byte/half out of the read word and extend it.
    function automatic logic [31:0] extract_load(input logic [2:0]  f3,
                                                 input logic [1:0]  off,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'b0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'b0, h};
            default: return word;
        endcase
    endfunction

    assign req_ready = (state_q == IDLE);
    assign dbg_state = state_q;

    // Decode the presented request: legality, alignment, lanes and data.
    always_comb begin
        dec_legal      = 1'b0;
        dec_misaligned = 1'b0;
        dec_strb       = 4'b0000;
        dec_wdata      = 32'h0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: dec_legal = 1'b1;
            3'b100, 3'b101:         dec_legal = !req_store;
            default:                dec_legal = 1'b0;
        endcase
        case (req_funct3[1:0])
            2'b01:   dec_misaligned = req_addr[0];
            2'b10:   dec_misaligned = (req_addr[1:0] != 2'b00);
            default: dec_misaligned = 1'b0;
        endcase
        if (req_store) begin
            case (req_funct3[1:0])
                2'b00: begin
                    dec_strb  = 4'b0001 << req_addr[1:0];
                    dec_wdata = {4{req_wdata[7:0]}};
                end
                2'b01: begin
                    dec_strb  = req_addr[1] ? 4'b1100 : 4'b0011;
                    dec_wdata = {2{req_wdata[15:0]}};
                end
                default: begin
                    dec_strb  = 4'b1111;
                    dec_wdata = req_wdata;
                end
            endcase
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        lat_store_d  = lat_store_q;
        lat_funct3_d = lat_funct3_q;
        lat_off_d    = lat_off_q;
        lat_rd_d     = lat_rd_q;
        mem_req_d    = mem_req;
        mem_we_d     = mem_we;
        mem_addr_d   = mem_addr;
        mem_wstrb_d  = mem_wstrb;
        mem_wdata_d  = mem_wdata;
        resp_valid_d = 1'b0;
        resp_we_d    = 1'b0;
        resp_rd_d    = 5'd0;
        resp_data_d  = 32'h0;
        resp_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    lat_store_d  = req_store;
                    lat_funct3_d = req_funct3;
                    lat_off_d    = req_addr[1:0];
                    lat_rd_d     = req_rd;
                    if (!dec_legal || dec_misaligned) begin
                        // Rejected up front: report the error, never touch memory.
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rd_d    = req_rd;
                    end else begin
                        state_d     = ACCESS;
                        cnt_d       = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_store;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_wstrb_d = dec_strb;
                        mem_wdata_d = dec_wdata;
                    end
                end
            end
            ACCESS: begin
                if (mem_ack || cnt_q == CNT_LAST) begin
                    state_d      = RESP;
                    cnt_d        = '0;
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = 32'h0;
                    mem_wstrb_d  = 4'b0000;
                    mem_wdata_d  = 32'h0;
                    resp_valid_d = 1'b1;
                    resp_rd_d    = lat_rd_q;
                    if (mem_ack) begin
                        resp_we_d   = !lat_store_q && (lat_rd_q != 5'd0);
                        resp_data_d = lat_store_q ? 32'h0
                                    : extract_load(lat_funct3_q, lat_off_q, mem_rdata);
                    end else begin
                        resp_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched request and all outputs; reset clears everything.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            lat_store_q  <= 1'b0;
            lat_funct3_q <= 3'b000;
            lat_off_q    <= 2'b00;
            lat_rd_q     <= 5'd0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= 32'h0;
            mem_wstrb    <= 4'b0000;
            mem_wdata    <= 32'h0;
            resp_valid   <= 1'b0;
            resp_we      <= 1'b0;
            resp_rd      <= 5'd0;
            resp_data    <= 32'h0;
            resp_err     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lat_store_q  <= lat_store_d;
            lat_funct3_q <= lat_funct3_d;
            lat_off_q    <= lat_off_d;
            lat_rd_q     <= lat_rd_d;
            mem_req      <= mem_req_d;
            mem_we       <= mem_we_d;
            mem_addr     <= mem_addr_d;
            mem_wstrb    <= mem_wstrb_d;
            mem_wdata    <= mem_wdata_d;
            resp_valid   <= resp_valid_d;
            resp_we      <= resp_we_d;
            resp_rd      <= resp_rd_d;
            resp_data    <= resp_data_d;
            resp_err     <= resp_err_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: drives directed and random RV32I loads/stores into
// load_store_unit, acts as the data memory, and checks every cycle against
// an access-level model of the expected memory window, ready window and
// response pulse.
module tb_load_store_unit;

    localparam int TMO = 16;

    logic        CLK, RST;
    logic        req_valid, req_ready, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        resp_valid, resp_we, resp_err;
    logic [4:0]  resp_rd;
    logic [31:0] resp_data;
    logic [1:0]  dbg_state;

    load_store_unit #(.MEM_TIMEOUT(TMO)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rd(req_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_we(resp_we), .resp_rd(resp_rd),
        .resp_data(resp_data), .resp_err(resp_err),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset / edge counter ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int e = 0;
    initial begin
        forever begin
            @(posedge CLK);
            e = e + 1;
        end
    end

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", name, act, exp, e);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired (edge %0d)", name, e);
    endtask

    // ---------------- behavioural model ----------------
    function automatic int model_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit model_legal(input bit st, input logic [2:0] f3);
        if (f3 <= 3'd2) return 1'b1;
        if (!st && (f3 == 3'd4 || f3 == 3'd5)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit model_misaligned(input logic [2:0] f3, input logic [31:0] addr);
        return (int'(addr[1:0]) % model_size(f3)) != 0;
    endfunction

    function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [31:0] addr);
        int sz, first;
        logic [3:0] r;
        sz = model_size(f3);
        first = int'(addr[1:0]);
        first = first - (first % sz);
        for (int i = 0; i < 4; i++) r[i] = (i >= first) && (i < first + sz);
        return r;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        int sz;
        logic [31:0] r;
        sz = model_size(f3);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] word);
        int sz, first;
        logic [63:0] v, mask;
        sz = model_size(f3);
        first = int'(addr[1:0]);
        first = first - (first % sz);
        mask = (64'd1 << (8*sz)) - 64'd1;
        v = ({32'h0, word} >> (8*first)) & mask;
        if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    // ---------------- expectation state ----------------
    logic [38:0] exp_q[$];       // {err, we, rd, data}
    int          exp_cyc_q[$];   // edge after which resp_valid is expected
    int          mq_first = 1, mq_last = 0;
    int          busy_first = 1, busy_last = 0;
    logic [31:0] mq_addr, mq_wdata;
    logic [3:0]  mq_strb;
    logic        mq_we;
    bit          cmp_en = 0;

    int          last_acc = 0, last_resp_edge = 0, mreq_cnt = 0;
    logic [31:0] last_mem_addr = 0, last_mem_wdata = 0, last_resp_data = 0;
    logic [3:0]  last_mem_strb = 0;
    logic [4:0]  last_resp_rd = 0;
    logic        last_resp_we = 0, last_resp_err = 0;

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge CLK);
            if (cmp_en) begin
                bit exp_mreq, exp_rv;
                logic [38:0] x;
                while (exp_cyc_q.size() > 0 && exp_cyc_q[0] < e) begin
                    void'(exp_cyc_q.pop_front());
                    void'(exp_q.pop_front());
                end
                exp_mreq = (e >= mq_first) && (e <= mq_last);
                chk("mem_req", {31'b0, mem_req}, {31'b0, exp_mreq});
                if (mem_req === 1'b1) mreq_cnt++;
                if (exp_mreq) begin
                    chk("mem_addr", mem_addr, mq_addr);
                    chk("mem_we", {31'b0, mem_we}, {31'b0, mq_we});
                    chk("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, mq_strb});
                    if (mq_we) chk("mem_wdata", mem_wdata, mq_wdata);
                    last_mem_addr  = mem_addr;
                    last_mem_strb  = mem_wstrb;
                    last_mem_wdata = mem_wdata;
                end
                chk("req_ready", {31'b0, req_ready},
                    {31'b0, !((e >= busy_first) && (e <= busy_last))});
                exp_rv = (exp_cyc_q.size() > 0) && (exp_cyc_q[0] == e);
                chk("resp_valid", {31'b0, resp_valid}, {31'b0, exp_rv});
                if (exp_rv) begin
                    void'(exp_cyc_q.pop_front());
                    x = exp_q.pop_front();
                    chk("resp_err", {31'b0, resp_err}, {31'b0, x[38]});
                    chk("resp_we", {31'b0, resp_we}, {31'b0, x[37]});
                    chk("resp_rd", {27'b0, resp_rd}, {27'b0, x[36:32]});
                    chk("resp_data", resp_data, x[31:0]);
                    last_resp_edge = e;
                    last_resp_data = resp_data;
                    last_resp_we   = resp_we;
                    last_resp_rd   = resp_rd;
                    last_resp_err  = resp_err;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd, input int k,
                         output bit pre_err);
        int g, ea, re;
        logic [31:0] d;
        bit we, err;
        pre_err = !model_legal(st, f3) || model_misaligned(f3, addr);
        mem_ack    = 1'($urandom_range(0, 1));
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        req_rd     = rd;
        g = 0;
        while (req_ready !== 1'b1 && g < 100) begin
            @(posedge CLK); #1;
            g++;
        end
        if (g >= 100) fail_now("accept_wait");
        @(posedge CLK); #1;
        ea = e;
        req_valid  = 1'b0;
        req_store  = 1'($urandom_range(0, 1));
        req_funct3 = 3'($urandom_range(0, 7));
        req_addr   = $urandom;
        req_wdata  = $urandom;
        req_rd     = 5'($urandom_range(0, 31));
        last_acc = ea;
        mreq_cnt = 0;
        d = 32'h0; we = 1'b0; err = 1'b0;
        if (pre_err) begin
            re  = ea;
            err = 1'b1;
        end else begin
            mq_first = ea;
            mq_last  = (k >= 0) ? ea + k : ea + TMO - 1;
            mq_addr  = {addr[31:2], 2'b00};
            mq_we    = st;
            mq_strb  = st ? model_strb(f3, addr) : 4'b0000;
            mq_wdata = model_wdata(f3, wd);
            if (k >= 0) begin
                re = ea + 1 + k;
                if (!st) begin
                    d  = model_load(f3, addr, mem_rdata_plan);
                    we = (rd != 5'd0);
                end
            end else begin
                re  = ea + TMO;
                err = 1'b1;
            end
        end
        busy_first = ea;
        busy_last  = re;
        exp_cyc_q.push_back(re);
        exp_q.push_back({err, we, rd, d});
    endtask

    logic [31:0] mem_rdata_plan = 0;

    task automatic serve(input int k);
        mem_ack = 1'b0;
        if (k >= 0) begin
            repeat (k) begin @(posedge CLK); #1; end
            mem_ack   = 1'b1;
            mem_rdata = mem_rdata_plan;
            @(posedge CLK); #1;
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
        end else begin
            repeat (TMO) begin @(posedge CLK); #1; end
            // Late ack after the timeout must be ignored.
            mem_ack   = 1'b1;
            mem_rdata = $urandom;
            repeat (2) begin @(posedge CLK); #1; end
            mem_ack = 1'b0;
        end
    endtask

    task automatic run_txn(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [4:0] rd, input int k,
                           input logic [31:0] rdata);
        bit pe;
        mem_rdata_plan = rdata;
        issue(st, f3, addr, wd, rd, k, pe);
        if (!pe) serve(k);
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((exp_cyc_q.size() != 0 || req_ready !== 1'b1) && g < 200) begin
            @(posedge CLK); #1;
            g++;
        end
        if (g >= 200) fail_now("wait_idle");
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int ea, k;
        bit st;
        logic [2:0] f3;
        RST = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;

        // Model pinned by hand-computed values.
        chk("model_lb", model_load(3'b000, 32'h103, 32'h80FF_7F01), 32'hFFFF_FF80);
        chk("model_lbu", model_load(3'b100, 32'h103, 32'h80FF_7F01), 32'h0000_0080);
        chk("model_lh", model_load(3'b001, 32'h22, 32'hABCD_0000), 32'hFFFF_ABCD);
        chk("model_sh_strb", {28'b0, model_strb(3'b001, 32'h22)}, 32'h0000_000C);
        chk("model_sh_data", model_wdata(3'b001, 32'h1234_ABCD), 32'hABCD_ABCD);
        chk("model_sb_strb", {28'b0, model_strb(3'b000, 32'h2)}, 32'h0000_0004);
        chk("model_lw_mis", {31'b0, model_misaligned(3'b010, 32'h6)}, 32'h1);

        repeat (3) begin @(posedge CLK); #1; end
        RST = 1'b0;
        mem_ack = 1'b0;
        chk("rst_ready", {31'b0, req_ready}, 32'h1);
        chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        chk("rst_resp_data", resp_data, 32'h0);
        cmp_en = 1;

        // SW, zero wait.
        run_txn(1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 5'd7, 0, 32'h0);
        wait_idle();
        chk("sw_addr", last_mem_addr, 32'h104);
        chk("sw_strb", {28'b0, last_mem_strb}, 32'hF);
        chk("sw_data", last_mem_wdata, 32'hDEAD_BEEF);
        chk("sw_latency", last_resp_edge - last_acc, 1);
        chk("sw_we", {31'b0, last_resp_we}, 32'h0);

        // LB / LBU / LB to x0.
        run_txn(1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd5, 1, 32'h80FF_7F01);
        wait_idle();
        chk("lb_data", last_resp_data, 32'hFFFF_FF80);
        chk("lb_we", {31'b0, last_resp_we}, 32'h1);
        chk("lb_rd", {27'b0, last_resp_rd}, 32'd5);
        run_txn(1'b0, 3'b100, 32'h0000_0103, 32'h0, 5'd5, 0, 32'h80FF_7F01);
        wait_idle();
        chk("lbu_data", last_resp_data, 32'h0000_0080);
        chk("lbu_we", {31'b0, last_resp_we}, 32'h1);
        run_txn(1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd0, 0, 32'h80FF_7F01);
        wait_idle();
        chk("lb_x0_we", {31'b0, last_resp_we}, 32'h0);

        // SH then LH of the same word.
        run_txn(1'b1, 3'b001, 32'h0000_0022, 32'h1234_ABCD, 5'd3, 2, 32'h0);
        wait_idle();
        chk("sh_strb", {28'b0, last_mem_strb}, 32'hC);
        chk("sh_data", last_mem_wdata, 32'hABCD_ABCD);
        run_txn(1'b0, 3'b001, 32'h0000_0022, 32'h0, 5'd4, 0, 32'hABCD_0000);
        wait_idle();
        chk("lh_data", last_resp_data, 32'hFFFF_ABCD);

        // Misaligned LW and illegal funct3.
        run_txn(1'b0, 3'b010, 32'h0000_0006, 32'h0, 5'd8, 0, 32'h0);
        wait_idle();
        chk("mis_err", {31'b0, last_resp_err}, 32'h1);
        chk("mis_latency", last_resp_edge - last_acc, 0);
        chk("mis_no_mreq", mreq_cnt, 0);
        chk("mis_data", last_resp_data, 32'h0);
        run_txn(1'b0, 3'b011, 32'h0000_0000, 32'h0, 5'd8, 0, 32'h0);
        wait_idle();
        chk("ill_err", {31'b0, last_resp_err}, 32'h1);
        chk("ill_no_mreq", mreq_cnt, 0);

        // Timeout with a late ack, then a normal LW.
        run_txn(1'b0, 3'b010, 32'h0000_0080, 32'h0, 5'd9, -1, 32'h0);
        wait_idle();
        chk("tmo_mreq_cycles", mreq_cnt, TMO);
        chk("tmo_err", {31'b0, last_resp_err}, 32'h1);
        run_txn(1'b0, 3'b010, 32'h0000_0040, 32'h0, 5'd10, 0, 32'h1122_3344);
        wait_idle();
        chk("post_tmo_lw", last_resp_data, 32'h1122_3344);

        // Reset during the third ACCESS cycle.
        begin
            bit pe;
            mem_rdata_plan = 32'h0;
            issue(1'b0, 3'b010, 32'h0000_0100, 32'h0, 5'd11, -1, pe);
            mem_ack = 1'b0;
            ea = last_acc;
            repeat (2) begin @(posedge CLK); #1; end
            RST = 1'b1;
            mq_last   = ea + 2;
            busy_last = ea + 2;
            exp_cyc_q.delete();
            exp_q.delete();
            @(posedge CLK); #1;
            RST = 1'b0;
            mem_ack = 1'b1;
            chk("midrst_ready", {31'b0, req_ready}, 32'h1);
            chk("midrst_mem_req", {31'b0, mem_req}, 32'h0);
            chk("midrst_mem_we", {31'b0, mem_we}, 32'h0);
            chk("midrst_mem_addr", mem_addr, 32'h0);
            chk("midrst_mem_wstrb", {28'b0, mem_wstrb}, 32'h0);
            chk("midrst_mem_wdata", mem_wdata, 32'h0);
            chk("midrst_resp", {26'b0, resp_valid, resp_we, resp_err, 3'b0}, 32'h0);
            chk("midrst_resp_rd", {27'b0, resp_rd}, 32'h0);
            chk("midrst_resp_data", resp_data, 32'h0);
            @(posedge CLK); #1;
            mem_ack = 1'b0;
        end
        run_txn(1'b0, 3'b010, 32'h0000_0200, 32'h0, 5'd12, 1, 32'hCAFE_F00D);
        wait_idle();
        chk("post_rst_lw", last_resp_data, 32'hCAFE_F00D);

        // Random traffic, sometimes back-to-back with req_valid held.
        for (int n = 0; n < 80; n++) begin
            st = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
            else if (st) f3 = 3'($urandom_range(0, 2));
            else begin
                f3 = 3'($urandom_range(0, 4));
                if (f3 == 3'd3) f3 = 3'd5;
            end
            k = ($urandom_range(0, 14) == 0) ? -1 : int'($urandom_range(0, 3));
            run_txn(st, f3, $urandom, $urandom, 5'($urandom_range(0, 31)), k, $urandom);
            if ($urandom_range(0, 1) == 0) wait_idle();
        end
        wait_idle();
        chk("exp_q_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound.
    initial begin
        #2000000;
        fail_now("global_timeout");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
